// File: rtl/ram_seq_pkg.sv
// Shared definitions for the RAM sequencer: the state encoding used by the
// sequencer and visible to anything that needs to decode its state.
package ram_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        DUMP  = 2'd3
    } state_e;

endpackage

// File: rtl/ram_sequencer.sv
// RAM sequencer: walks an external async-read RAM from address 0 to 2^A-1
// to zero-fill it, fill it from a valid/ready input stream, or stream its
// contents out through a valid/ready output. One operation at a time; a
// single-cycle done pulse marks completion.
module ram_sequencer
    import ram_seq_pkg::*;
#(
    parameter int A = 4,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_clear,
    input  logic         start_load,
    input  logic         start_dump,
    input  logic [D-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [D-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         done,
    output logic [A-1:0] mem_addr,
    output logic [D-1:0] mem_wdata,
    output logic         mem_we,
    input  logic [D-1:0] mem_rdata
);

    state_e         state_q, state_d;
    logic [A-1:0]   ptr_q, ptr_d;
    logic           done_q, done_d;
    logic           last;

    // The terminating step of every operation happens at the top address.
    assign last      = (ptr_q == {A{1'b1}});
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign mem_addr  = ptr_q;
    // Dump data comes straight from the RAM; it holds under backpressure
    // because the pointer does not move until the transfer completes.
    assign out_data  = mem_rdata;

    // State, pointer and done-pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    // Next-state, pointer advance and handshake/RAM outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned and infers a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        done_d    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;

        unique case (state_q)
            IDLE: begin
                // Clear wins over load, load wins over dump.
                if (start_clear) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end else if (start_load) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end else if (start_dump) begin
                    state_d = DUMP;
                    ptr_d   = '0;
                end
            end

            CLEAR: begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + A'(1);
                if (last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end

            LOAD: begin
                in_ready  = 1'b1;
                mem_wdata = in_data;
                if (in_valid) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + A'(1);
                    if (last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            DUMP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    ptr_d = ptr_q + A'(1);
                    if (last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/ram_sequencer.md
RAM_SEQUENCER -- requirements
Module: ram_sequencer

Interface
REQ-001 SHALL have parameter A, default 4, RAM address width in bits.
REQ-002 SHALL have parameter D, default 4, RAM data width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port start_clear  input  1  one-cycle request: zero-fill the RAM.
REQ-006 SHALL have port start_load  input  1  one-cycle request: fill the RAM from the input stream.
REQ-007 SHALL have port start_dump  input  1  one-cycle request: stream RAM contents out.
REQ-008 SHALL have port in_data  input  D  load stream data.
REQ-009 SHALL have port in_valid  input  1  in_data valid.
REQ-010 SHALL have port in_ready  output  1  sequencer accepts in_data this cycle.
REQ-011 SHALL have port out_data  output  D  dump stream data.
REQ-012 SHALL have port out_valid  output  1  out_data valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse when an operation completes.
REQ-016 SHALL have port mem_addr  output  A  RAM address.
REQ-017 SHALL have port mem_wdata  output  D  RAM write data.
REQ-018 SHALL have port mem_we  output  1  RAM write enable; the RAM writes on the same clk edge.
REQ-019 SHALL have port mem_rdata  input  D  RAM read data, combinational (async) from mem_addr.

Function
REQ-020 SHALL implement states IDLE, CLEAR, LOAD, DUMP, plus an A-bit pointer ptr; mem_addr = ptr at all times.
REQ-021 In IDLE, start_* SHALL move to the named state with ptr=0 on the next edge; if several are asserted, priority is clear > load > dump.
REQ-022 start_* SHALL be ignored outside IDLE.
REQ-023 CLEAR: mem_we=1 and mem_wdata=0 every cycle; ptr++ per cycle; the write at ptr=2^A-1 returns to IDLE. Total 2^A cycles.
REQ-024 LOAD: in_ready=1; on in_valid&in_ready, mem_we=1, mem_wdata=in_data, ptr++; no write when in_valid=0. The accepted word at ptr=2^A-1 returns to IDLE.
REQ-025 DUMP: out_valid=1, out_data=mem_rdata (zero added latency); on out_valid&out_ready, ptr++. The transfer at ptr=2^A-1 returns to IDLE.
REQ-026 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 done SHALL pulse high for exactly one cycle, in the first cycle back in IDLE after CLEAR, LOAD or DUMP completes.
REQ-028 Outside their states: in_ready=0, out_valid=0, mem_we=0; mem_wdata=0 except in LOAD.
REQ-029 ptr SHALL wrap from 2^A-1 to 0 on the terminating step.

Reset
REQ-030 When rst_n=0 at a clk edge: state=IDLE, ptr=0, done=0. Outputs: busy=0, in_ready=0, out_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, out_data=mem_rdata.
REQ-031 Reset mid-operation SHALL abort with no done pulse. RAM contents are not restored; words already written remain.
REQ-032 start_* sampled in the same cycle as rst_n=0 SHALL be ignored.

Structure
REQ-033 SHALL place the state encoding (IDLE=0, CLEAR=1, LOAD=2, DUMP=3, 2 bits) in a shared package, ram_seq_pkg.
REQ-034 SHALL contain no sub-module. The RAM is external; benches pair the block with the team's async-read RAM, using matching A and D.

Verification (A=4, D=4)
REQ-035 Clear: start_clear -> busy for 16 cycles, mem_we=1 on addresses 0..15, done on the 17th cycle; dump then yields 16 zeros.
REQ-036 Load/dump: load 0x0..0xF with in_valid gapped every other cycle -> 16 writes, done; dump with out_ready=1 -> out_data 0,1,...,F on consecutive cycles.
REQ-037 Backpressure: during dump, hold out_ready=0 for 3 cycles at ptr=5 -> out_data stays 5 and ptr stays 5; the stream resumes at 6.
REQ-038 Priority/ignore: start_clear and start_dump together -> CLEAR only. start_load during CLEAR -> ignored; still exactly 16 cycles.
REQ-039 Reset mid-load: rst_n=0 after 7 words -> busy=0 next cycle, no done; a following dump shows words 0..6 as loaded and words 7..15 as their prior values.
